// File: rtl/cheby_pkg.sv
// Shared constants and state encoding for the Chebyshev term MAC and its ROM wrappers.
package cheby_pkg;

    localparam int DATA_W  = 16;
    localparam int N_TERMS = 8;
    localparam int ADDR_W  = 3;
    localparam int ACC_W   = 2 * DATA_W + $clog2(N_TERMS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cheby_round_sat.sv
// Q30 accumulator -> Q15 result: round half up, shift, then clamp or wrap.
// Clamping is enabled by defining CHEBY_MAC_SAT_EN; otherwise the low bits wrap.
module cheby_round_sat #(
    parameter int ACC_W  = 35,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [DATA_W-1:0] o_sum
);

    localparam int SH = DATA_W - 1;
    localparam int SW = ACC_W - SH;

    logic signed [ACC_W-1:0] w_biased;
    logic signed [SW-1:0]    w_shifted;

    assign w_biased  = i_acc + (ACC_W'(1) << (SH - 1));
    // Taking the upper bits of a signed word is the arithmetic shift right.
    assign w_shifted = w_biased[ACC_W-1:SH];

`ifdef CHEBY_MAC_SAT_EN
    logic signed [SW-1:0] w_max;
    logic signed [SW-1:0] w_min;
    logic                 w_unused_low;

    assign w_max        = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    assign w_min        = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    assign w_unused_low = ^w_biased[SH-1:0];

    always_comb begin
        o_sum = w_shifted[DATA_W-1:0];
        if (w_shifted > w_max) begin
            o_sum = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shifted < w_min) begin
            o_sum = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    logic w_unused_bits;

    assign w_unused_bits = ^{w_biased[SH-1:0], w_shifted[SW-1:DATA_W]};
    assign o_sum         = w_shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/cheby_term_mac.sv
// Walks the Chebyshev term ROM, multiplies each T_k word by c_k and accumulates sum c_k*T_k.
// Saturating output is selected with CHEBY_MAC_SAT_EN (see cheby_round_sat).
module cheby_term_mac
    import cheby_pkg::*;
(
    input  logic              c_clk,
    input  logic              c_reset,
    input  logic              c_start,
    input  logic [DATA_W-1:0] i_rom_data,
    input  logic [DATA_W-1:0] i_coef,
    output logic [ADDR_W-1:0] o_rom_address,
    output logic              c_rom_read_en,
    output logic              c_rom_ce,
    output logic              c_rom_tri_output,
    output logic [ADDR_W-1:0] o_coef_index,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_valid,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    localparam int PROD_W = 2 * DATA_W;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_k;
    logic signed [PROD_W-1:0]  r_prod;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]         r_sum;

    logic signed [PROD_W-1:0]  w_rom_ext;
    logic signed [PROD_W-1:0]  w_coef_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]         w_rounded;
    logic                      w_last;
    logic                      w_fetch;

    assign w_rom_ext  = {{DATA_W{i_rom_data[DATA_W-1]}}, i_rom_data};
    assign w_coef_ext = {{DATA_W{i_coef[DATA_W-1]}}, i_coef};
    assign w_acc_next = r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_last     = (r_k == ADDR_W'(N_TERMS - 1));
    assign w_fetch    = (r_state == ST_FETCH);

    // The DRAIN-cycle sum is rounded directly so o_sum is already new while o_valid is high.
    cheby_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_round_sat (
        .i_acc (w_acc_next),
        .o_sum (w_rounded)
    );

    always_ff @(posedge c_clk) begin
        if (c_reset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (c_start) begin
                        r_state <= ST_FETCH;
                        r_k     <= '0;
                        r_prod  <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_FETCH: begin
                    r_prod <= w_rom_ext * w_coef_ext;
                    r_acc  <= w_acc_next;
                    if (w_last) begin
                        r_k     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_acc   <= w_acc_next;
                    r_sum   <= w_rounded;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // o_valid is a bare one-cycle strobe with no back-pressure: a consumer must take o_sum then.
    assign o_rom_address    = r_k;
    assign o_coef_index     = r_k;
    assign c_rom_ce         = w_fetch;
    assign c_rom_read_en    = w_fetch;
    assign c_rom_tri_output = ~w_fetch;
    assign o_sum            = r_sum;
    assign o_valid          = (r_state == ST_DONE);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_dbg_state      = r_state;

endmodule

// File: doc/cheby_term_mac.md
# cheby_term_mac

Sequencer and multiply-accumulate stage directly downstream of the per-node Chebyshev term ROMs (T_k(x) words, Q15, 8 entries, 3-bit address). On a start pulse it walks the ROM address 0..N_TERMS-1 and multiplies each T_k word by coefficient c_k. It accumulates the products and presents the Q15 filter tap sum y = sum c_k·T_k(x) with a one-cycle valid strobe. It drives the ROM's chip-enable, read-enable and active-low tristate control itself.

## Interface
- N_TERMS, 8, number of Chebyshev terms; ROM depth, 2..8
- DATA_W, 16, width of ROM word, coefficient and result (signed Q15)
- ACC_W, 35, accumulator width (2·DATA_W + ceil(log2 N_TERMS))
- c_clk  in  1  sole clock, rising edge
- c_reset  in  1  synchronous, active-high reset
- c_start  in  1  request one evaluation; sampled only in IDLE
- i_rom_data  in  DATA_W  T_k word from ROM (combinational w.r.t. o_rom_address)
- i_coef  in  DATA_W  signed Q15 coefficient c_k for o_coef_index (combinational source)
- o_rom_address  out  3  ROM address k
- c_rom_read_en  out  1  ROM read enable
- c_rom_ce  out  1  ROM chip enable
- c_rom_tri_output  out  1  ROM output tristate, active low (0 = ROM drives bus)
- o_coef_index  out  3  coefficient index; always equal to o_rom_address
- o_sum  out  DATA_W  result, held until next DONE
- o_valid  out  1  one-cycle strobe, o_sum new
- o_busy  out  1  high in FETCH, DRAIN, DONE

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: c_rom_ce=0, c_rom_read_en=0, c_rom_tri_output=1, address 0. c_start=1 -> FETCH, k=0, accumulator and product register cleared.
- FETCH: c_rom_ce=1, c_rom_read_en=1, c_rom_tri_output=0; o_rom_address=k. Each cycle: product register <= i_rom_data × i_coef (full 2·DATA_W signed, Q30); accumulator += previous product register. k increments; after k=N_TERMS-1 -> DRAIN.
- DRAIN: ROM controls return to IDLE values; accumulator += last product.
- DONE: o_sum <= round_sat(accumulator); o_valid=1; -> IDLE.
- round_sat: add 2^14, arithmetic shift right 15 (round half up), then width reduction per Configuration.
- c_start in FETCH/DRAIN/DONE ignored; no queueing. c_start held high restarts on the first IDLE cycle.
- Reset: all state cleared, state=IDLE, takes priority over every other event including an in-flight evaluation; no o_valid for an aborted run.

## Timing
- Reset values: o_rom_address=0, o_coef_index=0, c_rom_ce=0, c_rom_read_en=0, c_rom_tri_output=1, o_sum=0, o_valid=0, o_busy=0.
- Start sampled at edge 0: FETCH on cycles 1..N_TERMS, DRAIN cycle N_TERMS+1, o_valid high cycle N_TERMS+2 (10 for N_TERMS=8), IDLE cycle N_TERMS+3.
- Continuous c_start: one result every N_TERMS+3 cycles (11).
- ROM path: one combinational ROM + coefficient lookup + multiply per cycle; no ROM wait states.

## Configuration
- CHEBY_MAC_SAT_EN defined: rounded result clamped to [0x8000, 0x7FFF].
- Undefined: low DATA_W bits of rounded result taken (two's-complement wrap); no clamp logic.

## Structure
- Package cheby_pkg: DATA_W, N_TERMS, ACC_W, state enum (IDLE/FETCH/DRAIN/DONE); shared with the ROM wrappers.
- Sub-module cheby_round_sat: combinational round-half-up, shift and optional saturation, ACC_W -> DATA_W; the macro is honoured only inside it.

## Test plan
- Real T(x7) ROM, c_0=0x4000, other c_k=0, start -> o_valid on cycle 10, o_sum=0x4000.
- Real ROM, c_4=0x8000, others 0 -> o_sum=0x37C0 (-1 × 0xC840).
- Stub ROM all 0x7FFF, all c_k=0x7FFF -> o_sum=0x7FFF with CHEBY_MAC_SAT_EN; 0xFFF0 without.
- Check ROM controls: ce/read_en=1, tri=0 exactly on cycles 1..8; o_rom_address 0..7 in order; tri=1 in IDLE.
- c_reset on FETCH k=3 -> next cycle IDLE, all reset values, no o_valid; new start then gives the correct result.
- c_start pulsed during FETCH ignored; c_start held high -> o_valid at cycles 10, 21, 32, identical o_sum.
